// File: rtl/fis_pkg.sv
// rtl/fis_pkg.sv - shared constants and types for the fast inverse-sqrt Wishbone controller
// Contents: register word offsets, STATUS bit positions, controller state enum.
package fis_pkg;

    // Word offsets on wb_adr_i[4:2]
    localparam logic [2:0] ADDR_OPERAND = 3'd0;
    localparam logic [2:0] ADDR_RESULT  = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;

    // STATUS register bit positions
    localparam int STAT_BUSY    = 0;
    localparam int STAT_AVAIL   = 1;
    localparam int STAT_FULL    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_UNF     = 4;
    localparam int STAT_TMO     = 5;
    localparam int STAT_CNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/fis_wb_ctrl_if.sv
// rtl/fis_wb_ctrl_if.sv - Wishbone slave port plus core request/result streams
// Ports: wb_* Wishbone slave signals; req_* operand stream to the core;
//        res_* result stream from the core. W is the core word width.
// Modports: slave = controller view, master = bus/core-side view.
interface fis_wb_ctrl_if #(
    parameter int W = 16
);
    logic [2:0]   wb_adr_i;
    logic [31:0]  wb_dat_i;
    logic [3:0]   wb_sel_i;
    logic         wb_we_i;
    logic         wb_cyc_i;
    logic         wb_stb_i;
    logic [31:0]  wb_dat_o;
    logic         wb_ack_o;
    logic [W-1:0] req_data;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] res_data;
    logic         res_valid;
    logic         res_ready;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o,
        output req_data, req_valid,
        input  req_ready,
        input  res_data, res_valid,
        output res_ready
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o,
        input  req_data, req_valid,
        output req_ready,
        output res_data, res_valid,
        input  res_ready
    );
endinterface

// File: rtl/fis_res_fifo.sv
// rtl/fis_res_fifo.sv - synchronous result FIFO, power-of-two depth
// Ports: clk, rst (async, active-high); push_i/push_data_i write side;
//        pop_i/head_o read side (head is the current oldest entry);
//        full_o, empty_o, count_o (0..DEPTH).
module fis_res_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Pop of an empty FIFO and push into a full one are ignored.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/fis_wb_ctrl.sv
// rtl/fis_wb_ctrl.sv - Wishbone initiator/result collector for the fast inverse-sqrt core
// Ports: clk, rst (async, active-high), bus (fis_wb_ctrl_if.slave: Wishbone
//        slave, req_* operand stream out, res_* result stream in).
// Optional: define FIS_TIMEOUT_EN for a watchdog that abandons a request
//        after TIMEOUT_CYCLES cycles in ISSUE/WAIT and sets STATUS.TMO.
module fis_wb_ctrl
    import fis_pkg::*;
#(
    parameter int INT_WIDTH      = 12,
    parameter int FRACT_WIDTH    = 4,
    parameter int RES_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          rst,
    fis_wb_ctrl_if.slave  bus
);
    localparam int W  = INT_WIDTH + FRACT_WIDTH;
    localparam int CW = $clog2(RES_DEPTH + 1);

    ctrl_state_t   state_q, state_d;
    logic          ack_q;
    logic [31:0]   dat_q, dat_d;
    logic [W-1:0]  req_data_q;
    logic          ovf_q, unf_q, tmo_q;
    logic          acc, op_wr, res_rd, st_wr;
    logic          push, pop, full, empty, res_rdy, tmo_hit;
    logic [W-1:0]  head;
    logic [CW-1:0] count;
    logic [31:0]   status;

    // One access per ack: the cycle carrying the ack cannot start another.
    assign acc    = bus.wb_cyc_i && bus.wb_stb_i && !ack_q;
    assign op_wr  = acc &&  bus.wb_we_i && (bus.wb_adr_i == ADDR_OPERAND);
    assign res_rd = acc && !bus.wb_we_i && (bus.wb_adr_i == ADDR_RESULT);
    assign st_wr  = acc &&  bus.wb_we_i && (bus.wb_adr_i == ADDR_STATUS);

    assign res_rdy = (state_q == WAIT) && !full;
    assign push    = bus.res_valid && res_rdy && !tmo_hit;
    assign pop     = res_rd && !empty;

    fis_res_fifo #(.WIDTH(W), .DEPTH(RES_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (bus.res_data),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (full),
        .empty_o     (empty),
        .count_o     (count)
    );

`ifdef FIS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q;

    // Held at zero in IDLE, so it starts from zero on entering ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  tmo_cnt_q <= '0;
        else if (state_q == IDLE) tmo_cnt_q <= '0;
        else                      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
    assign tmo_hit = (state_q != IDLE) && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] unused_tmo_cfg;
    assign unused_tmo_cfg = 32'(TIMEOUT_CYCLES);
    assign tmo_hit        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (op_wr)         state_d = ISSUE;
            ISSUE:   if (bus.req_ready) state_d = WAIT;
            WAIT:    if (push)          state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
        if (tmo_hit) state_d = IDLE;
    end

    always_comb begin
        status                            = '0;
        status[STAT_BUSY]                 = (state_q != IDLE);
        status[STAT_AVAIL]                = !empty;
        status[STAT_FULL]                 = full;
        status[STAT_OVF]                  = ovf_q;
        status[STAT_UNF]                  = unf_q;
        status[STAT_TMO]                  = tmo_q;
        status[STAT_CNT_LSB +: CW]        = count;
    end

    always_comb begin
        dat_d = '0;
        if (acc && !bus.wb_we_i) begin
            case (bus.wb_adr_i)
                ADDR_RESULT: if (!empty) dat_d[W-1:0] = head;
                ADDR_STATUS: dat_d = status;
                default:     dat_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            req_data_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= acc;
            dat_q   <= dat_d;
            if (op_wr && state_q == IDLE) req_data_q <= bus.wb_dat_i[W-1:0];
            // Sticky flags: a set event in the same cycle as W1C wins.
            if (op_wr && state_q != IDLE)         ovf_q <= 1'b1;
            else if (st_wr && bus.wb_dat_i[STAT_OVF]) ovf_q <= 1'b0;
            if (res_rd && empty)                  unf_q <= 1'b1;
            else if (st_wr && bus.wb_dat_i[STAT_UNF]) unf_q <= 1'b0;
            if (tmo_hit)                          tmo_q <= 1'b1;
            else if (st_wr && bus.wb_dat_i[STAT_TMO]) tmo_q <= 1'b0;
        end
    end

    assign bus.wb_ack_o  = ack_q;
    assign bus.wb_dat_o  = dat_q;
    assign bus.req_valid = (state_q == ISSUE);
    assign bus.req_data  = req_data_q;
    assign bus.res_ready = res_rdy;

    logic unused_bits;
    assign unused_bits = ^{bus.wb_sel_i, bus.wb_dat_i[31:W]};
endmodule

// File: doc/fis_wb_ctrl.md
Name: fis_wb_ctrl

Overview:
Wishbone-side initiator and result collector for the fixed-point fast inverse-sqrt core. It drives the core's request stream (data/valid/ready) from CPU register writes. It sinks the core's result stream into a small result FIFO that the CPU drains by register reads. Sits between the SweRVolf Wishbone interconnect and the core, one request outstanding at a time.

Parameters:
INT_WIDTH, 12, integer bits of core fixed-point word
FRACT_WIDTH, 4, fractional bits of core fixed-point word
RES_DEPTH, 4, result FIFO depth; power of two, 2..16
TIMEOUT_CYCLES, 64, watchdog limit (used only with FIS_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
wb_adr_i  in  3  word address [4:2]
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte enables (ignored; full-word access only)
wb_we_i  in  1  write enable
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_dat_o  out  32  read data
wb_ack_o  out  1  acknowledge
req_data  out  W  operand to core (W = INT_WIDTH+FRACT_WIDTH)
req_valid  out  1  operand valid
req_ready  in  1  core ready to accept
res_data  in  W  core result
res_valid  in  1  core result valid
res_ready  out  1  this block ready to accept result

Behaviour:
- Reset: wb_ack_o=0, wb_dat_o=0, req_valid=0, req_data=0, res_ready=0, FIFO empty, sticky flags 0, FSM IDLE.
- Bus access:
  - Accepted in the cycle cyc&stb&!wb_ack_o; side effects happen in that cycle.
  - wb_ack_o is a registered single-cycle pulse on the next cycle, with wb_dat_o registered alongside it.
  - Back-to-back accesses therefore take 2 cycles each.
- Register map:
  - 0x00 OPERAND (W): if FSM IDLE, latch wb_dat_i[W-1:0] into req_data and go to ISSUE. Otherwise drop the write and set OVF. Reads return 0.
  - 0x04 RESULT (R): if FIFO non-empty, return zero-extended head and pop. If empty, return 0 and set UNF. Writes are ignored.
  - 0x08 STATUS (R): bit0 BUSY (FSM!=IDLE), bit1 AVAIL (count>0), bit2 FULL, bit3 OVF, bit4 UNF, bit5 TMO, bits[12:8] count. Write: W1C on bits 3..5.
  - Other addresses: ack, read 0, no effect.
- FSM:
  - IDLE -> ISSUE on accepted OPERAND write.
  - ISSUE: req_valid=1, req_data stable. Handshake on req_valid&req_ready, then -> WAIT. req_valid deasserts the cycle after the handshake.
  - WAIT: res_ready = !FULL. On res_valid&res_ready, push res_data and go -> IDLE.
  - res_ready is 0 outside WAIT; res_valid outside WAIT is ignored.
- Request-to-result latency is set by the core. This block adds 1 cycle (OPERAND write to req_valid) plus 1 cycle (capture to AVAIL).
- FIFO boundaries:
  - Push and pop in the same cycle: count unchanged, data order preserved.
  - When full, WAIT holds res_ready=0. The core must hold its result until a pop frees space; there is no loss.
  - Pointers wrap modulo RES_DEPTH; count is a separate register in the range 0..RES_DEPTH.
- OPERAND write in the same cycle as a result capture (WAIT->IDLE): the write sees BUSY=1 and is dropped with OVF set.
- rst asserted mid-transaction: everything returns to reset values immediately, including FIFO contents. The core shares the same rst.

Optional Feature:
- Macro FIS_TIMEOUT_EN.
- With it: a counter runs while in ISSUE or WAIT and clears on entering ISSUE. When it reaches TIMEOUT_CYCLES, the FSM forces IDLE, drops req_valid, sets TMO and pushes nothing.
- Without it: no counter; STATUS bit5 reads 0; the FSM waits indefinitely.

Decomposition:
- Package fis_pkg holds:
  - register offset localparams (ADDR_OPERAND/RESULT/STATUS)
  - STATUS bit index localparams
  - ctrl_state_t enum {IDLE, ISSUE, WAIT}
- One sub-module, fis_res_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised by width and depth, same clk/rst.

Test Plan:
- Bench core stub returns data^'hFFFF 5 cycles after accept, holding res_valid until res_ready.
- Write OPERAND 0x0040 -> req_valid seen with req_data=0x0040; STATUS later reads AVAIL=1, count=1; RESULT read = 0x0000FFBF; STATUS count=0.
- Write OPERAND 0x0010, then OPERAND 0x0020 while BUSY -> second write dropped, OVF=1. Write 0x08 to STATUS clears OVF. Only one result (0xFFEF) is present.
- Five operands with no reads (RES_DEPTH=4) -> first four results queued and FULL=1. The fifth is held by the stub with res_ready=0 and BUSY=1. One RESULT read returns the first result, the fifth capture follows, and count returns to 4.
- RESULT read when empty -> returns 0 and UNF=1; W1C 0x10 clears it.
- Assert rst during WAIT with 2 results queued -> req_valid=0, res_ready=0, count=0, BUSY=0 on the cycle rst rises.
- FIS_TIMEOUT_EN defined, stub never returns, TIMEOUT_CYCLES=64 -> TMO=1 and BUSY=0 after 64 cycles. A new OPERAND write is then accepted.
